// File: rtl/conv3x3_stream_engine.sv
// 3x3 valid convolution over a captured square image, NF filters per pixel; CONV_SIGNED_RELU_EN selects signed/ReLU math.
// First beat one cycle after start capture, one pixel per accepted beat; stalls hold the beat and the counter.
module conv3x3_stream_engine #(
    parameter int IMG_W = 12,
    parameter int DW    = 2,
    parameter int OW    = 2,
    parameter int NF    = 2,
    localparam int NP   = (IMG_W - 2) * (IMG_W - 2),
    localparam int IW   = (NP > 1) ? $clog2(NP) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [IMG_W*IMG_W*DW-1:0] in_img,
    input  logic [NF*9*DW-1:0]       filters,
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [IW-1:0]            out_idx,
    output logic [NF*OW-1:0]         out_data,
    output logic [NF*NP*OW-1:0]      out_img,
    output logic                     done
);

    localparam int AW = 2 * DW + 4;
    localparam int CW = $clog2(IMG_W);
    localparam logic [AW-1:0] SAT = AW'((1 << OW) - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]                 state;
    logic [IMG_W*IMG_W*DW-1:0]  img_q;
    logic [NF*9*DW-1:0]         flt_q;
    logic [IW-1:0]              cnt;
    logic [CW-1:0]              row;
    logic [CW-1:0]              col;
    logic [NF*OW-1:0]           conv_res;
    logic                       issue;

    function automatic logic [AW-1:0] ext(input logic [DW-1:0] v);
`ifdef CONV_SIGNED_RELU_EN
        return {{(AW-DW){v[DW-1]}}, v};
`else
        return {{(AW-DW){1'b0}}, v};
`endif
    endfunction

    function automatic logic [OW-1:0] sat(input logic [AW-1:0] a);
`ifdef CONV_SIGNED_RELU_EN
        if (a[AW-1]) return '0;
`endif
        if (a > SAT) return '1;
        return OW'(a);
    endfunction

    // Products are taken at accumulator width so sign extension carries through in the signed build.
    always_comb begin
        logic [AW-1:0] acc;
        logic [AW-1:0] pe;
        logic [AW-1:0] we;
        int            pi;
        acc      = '0;
        pe       = '0;
        we       = '0;
        pi       = 0;
        conv_res = '0;
        for (int f = 0; f < NF; f++) begin
            acc = '0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    pi  = (int'(row) + i) * IMG_W + int'(col) + j;
                    pe  = ext(img_q[pi*DW +: DW]);
                    we  = ext(flt_q[(f*9 + i*3 + j)*DW +: DW]);
                    acc = acc + pe * we;
                end
            end
            conv_res[f*OW +: OW] = sat(acc);
        end
    end

    assign busy  = (state != S_IDLE);
    assign issue = (state == S_RUN) && !abort && (!out_valid || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            img_q     <= '0;
            flt_q     <= '0;
            cnt       <= '0;
            row       <= '0;
            col       <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
            out_img   <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        img_q <= in_img;
                        flt_q <= filters;
                        cnt   <= '0;
                        row   <= '0;
                        col   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end else if (issue) begin
                        out_data  <= conv_res;
                        out_idx   <= cnt;
                        out_valid <= 1'b1;
                        for (int f = 0; f < NF; f++) begin
                            out_img[(f*NP + int'(cnt))*OW +: OW] <= conv_res[f*OW +: OW];
                        end
                        cnt <= cnt + 1'b1;
                        if (col == CW'(IMG_W - 3)) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                        if (cnt == IW'(NP - 1)) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_DONE;
                    end
                end
                default: begin
                    // An abort landing on the final cycle still suppresses the done pulse.
                    if (!abort) done <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/conv3x3_stream_engine.md
Name: conv3x3_stream_engine

Overview:
Parametrised sequential 3x3 valid-convolution engine, successor to the combinational PE arrays in the NN datapath. Captures one flattened square image plus NF filters on start. Produces (IMG_W-2)^2 output pixels in raster order, one per accepted cycle, on a valid/ready stream. Also builds a flattened output image that can feed the next layer's engine directly.

Parameters:
IMG_W, 12, input image side length in pixels (>=3)
DW, 2, pixel and weight width in bits
OW, 2, output pixel width in bits (saturated)
NF, 2, number of filters evaluated in parallel per pixel

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a job; sampled only in IDLE
abort  input  1  synchronous job cancel
in_img  input  IMG_W*IMG_W*DW  pixel (r,c) at bits [(r*IMG_W+c)*DW +: DW]
filters  input  NF*9*DW  weight (i,j) of filter f at [(f*9+i*3+j)*DW +: DW]
busy  output  1  high whenever state != IDLE
out_valid  output  1  out_data/out_idx valid
out_ready  input  1  consumer accepts the current beat
out_idx  output  clog2((IMG_W-2)^2)  raster index r*(IMG_W-2)+c of the current beat
out_data  output  NF*OW  filter f result at [f*OW +: OW]
out_img  output  NF*(IMG_W-2)^2*OW  plane f, pixel p at [(f*(IMG_W-2)^2+p)*OW +: OW]
done  output  1  one-cycle pulse on job completion

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, out_valid, done = 0; out_idx, out_data, out_img, counters, captured regs = 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 at edge -> capture in_img and filters, zero pixel counter, go to RUN. in_img and filters are don't-care afterward.
- RUN, issue rule: a new beat issues at an edge when (!out_valid || out_ready). Each issue loads out_data = conv(r,c) for all f, sets out_idx, writes the same values into out_img, sets out_valid=1, and advances the counter.
- RUN -> DRAIN at the edge that issues the last pixel (index (IMG_W-2)^2-1).
- DRAIN: when out_ready=1 -> out_valid=0, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Stall: while out_valid=1 and out_ready=0, out_data and out_idx stay stable and the counter holds.
- Latency: first out_valid at the edge after the start-capture edge. With out_ready tied high, a job takes (IMG_W-2)^2+3 cycles from start to done.
- Arithmetic: conv(r,c) = sum over i,j of pix(r+i,c+j)*w(i,j). Unsigned, 2*DW+4-bit accumulator, no overflow. Result saturates to 2^OW-1.
- start while busy: ignored, no effect.
- abort=1 in any non-IDLE state: next edge -> IDLE, out_valid=0, no done pulse. out_img keeps its partial contents. abort wins over issue at the same edge.
- out_img holds its value from one job until it is overwritten pixel-by-pixel in the next job. No clear on start.
- rst_n low mid-job: immediate return to reset values, including out_img.

Optional Feature:
Macro CONV_SIGNED_RELU_EN.
- Defined: pixels and weights are two's-complement signed and the accumulator is signed. Negative sums clamp to 0 (ReLU); positive sums saturate to 2^OW-1.
- Undefined: unsigned arithmetic as specified under Behaviour.
- Ports and timing are identical in both builds.

Test Plan:
- IMG_W=4, DW=2, OW=4, NF=1; image all 1, filter all 1, out_ready=1 -> 4 beats, idx 0..3, data 9 each. done at cycle 7 after start. out_img = 0x9999.
- Default params; filter0 center weight=1, others 0; filter1 all 3; image ramp pix=(r+c)%4 -> plane0 equals inner pixels (r+1+c+1)%4. Every plane1 value saturates to 3.
- IMG_W=4, OW=4; out_ready low for 3 cycles after the first beat -> idx 0 and data held stable. Counter frozen. Total job extended by exactly 3 cycles.
- Assert start again during RUN with a different image -> ignored. Outputs still match the first image; only one done pulse.
- abort on the 2nd beat -> next cycle busy=0, out_valid=0, no done. A new start then completes correctly.
- rst_n pulsed low mid-RUN -> all outputs 0 immediately. With CONV_SIGNED_RELU_EN: image all 1, weights all -1 (2'b11) -> every output 0.
